jamma_input_scanner: RTL
========================

Name: jamma_input_scanner

Overview:
- Front-end for the arcade top-level player inputs.
- Drives the JAMMA adapter's player-select line and time-multiplexes the shared 8-bit JJOY bus into two per-player registers.
- Synchronises and debounces the multiplexed joystick bus and the coin/test/service lines; merges the local DB9 joystick into player 1.
- Feeds clean active-low joystick1/joystick2/coin vectors to the game core; replaces the free-running toggle in the top level.

Parameters:
- SETTLE_CYCLES, 4, clk cycles JSELECT is held after each change before JJOY is sampled (1..255).
- DEBOUNCE_SCANS, 3, consecutive identical samples needed before a debounced bit changes (1..15).

Ports:
- clk  in  1  system clock (pclk domain).
- rst_n  in  1  asynchronous, active-low reset.
- jamma_joy  in  8  shared JAMMA joystick/button bus, active-low, asynchronous.
- jamma_coin  in  2  coin switches, active-low, asynchronous.
- jamma_test  in  1  test switch, active-low, asynchronous.
- jamma_service  in  1  service switch, active-low, asynchronous.
- local_joy  in  6  DB9 joystick, active-low, asynchronous.
- jselect  out  1  adapter player select: 0 = player 1, 1 = player 2.
- joy1  out  8  debounced player 1, active-low.
- joy2  out  8  debounced player 2, active-low.
- coin  out  2  debounced coin, active-low.
- test_n  out  1  debounced test.
- service_n  out  1  debounced service.
- scan_done  out  1  one-cycle pulse after each player-2 sample.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: jselect=0; joy1, joy2 = 8'hFF; coin = 2'b11; test_n = service_n = 1; scan_done = 0; FSM = SETTLE_P1; settle counter = 0; debounce counters = 0; synchroniser flops = 1.
- All asynchronous inputs pass through a 2-flop synchroniser, reset to 1.
- FSM, four states:
  - SETTLE_P1: jselect=0; count SETTLE_CYCLES cycles, then go to SAMPLE_P1.
  - SAMPLE_P1: capture sync(jamma_joy) & {2'b11, sync(local_joy)} as the P1 raw sample; go to SETTLE_P2.
  - SETTLE_P2: jselect=1; count SETTLE_CYCLES cycles, then go to SAMPLE_P2.
  - SAMPLE_P2: capture sync(jamma_joy) as the P2 raw sample; also capture the coin/test/service raw samples; assert scan_done for that cycle; go to SETTLE_P1.
- jselect is registered and changes on entry to SETTLE_P1 / SETTLE_P2. Scan period = 2*(SETTLE_CYCLES+1) cycles (10 at default).
- Settle counter is 8-bit, cleared on every state entry. No wrap is possible because the counter is bounded by SETTLE_CYCLES.
- Debounce, one counter per bit (4-bit, 20 bits total), evaluated only on that bit's sample cycle:
  - sample == current output: counter cleared.
  - otherwise: counter increments; when it reaches DEBOUNCE_SCANS the output takes the sample and the counter clears.
  - A glitch shorter than DEBOUNCE_SCANS scans never propagates. Counter saturation is impossible.
- Latency: an edge on jamma_joy reaches joy1/joy2 after at most 2 (sync) + DEBOUNCE_SCANS scan periods + 1 cycles.
- Simultaneous change of several bits: each bit is handled independently; no cross-bit coupling.
- Reset mid-scan: immediate return to reset values. The first valid sample is taken SETTLE_CYCLES+1 cycles after rst_n deasserts.

Optional Feature:
- Macro: JAMMA_DEBOUNCE_EN.
- Defined: debounce as above.
- Undefined: debounce counters are removed; each output register loads its raw sample directly on its sample cycle (latency 2 sync cycles + at most one scan period). FSM and jselect timing are unchanged.

Decomposition:
- Shared package jamma_pkg holds:
  - FSM state typedef (SETTLE_P1, SAMPLE_P1, SETTLE_P2, SAMPLE_P2).
  - Constants JOY_W=8, LOCAL_W=6, COIN_W=2.
  - Released-input constant JOY_IDLE=8'hFF.
- One natural sub-module, jamma_debounce_bit: a single-bit sample-enabled debouncer, parameterised by DEBOUNCE_SCANS, instantiated 20 times.

Test Plan:
- Reset/idle: rst_n low for 5 cycles with all inputs 1 -> all outputs at reset values; jselect toggles with period 10 cycles once rst_n rises.
- Player separation: adapter model drives 8'h7E when jselect=0 and 8'hBD when jselect=1 -> after 2+3 scans, joy1=8'h7E and joy2=8'hBD, stable thereafter.
- Local merge: local_joy=6'b111110 with jamma_joy=8'hFF -> joy1=8'hFE; joy2 stays 8'hFF.
- Glitch rejection: jamma_coin[0] low for 2 scans, then high -> coin stays 2'b11. Low for 4 scans -> coin=2'b10 after 3 scans. With JAMMA_DEBOUNCE_EN undefined, coin=2'b10 within one scan.
- Reset mid-operation: rst_n pulsed low during SETTLE_P2 while joy2=8'h00 -> jselect=0 and joy2=8'hFF at once; next sample occurs 5 cycles after release.
- scan_done: exactly one pulse per 10 cycles, coincident with SAMPLE_P2; never asserted during reset.

Source files
------------

// File: rtl/jamma_pkg.sv
// Shared types and widths for the JAMMA player-input scanner.
package jamma_pkg;

  localparam int JOY_W   = 8;
  localparam int LOCAL_W = 6;
  localparam int COIN_W  = 2;

  localparam logic [JOY_W-1:0] JOY_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    SETTLE_P1,
    SAMPLE_P1,
    SETTLE_P2,
    SAMPLE_P2
  } scan_state_t;

endpackage

// File: rtl/jamma_debounce_bit.sv
// Single-bit debouncer: the output follows the input only after DEBOUNCE_SCANS
// consecutive differing samples, evaluated on sample_en cycles only.
module jamma_debounce_bit #(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic sample,
  output logic q
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= 1'b1;
      cnt <= '0;
    end else if (sample_en) begin
      if (sample == q) begin
        cnt <= '0;
      end else if (cnt == 4'(DEBOUNCE_SCANS - 1)) begin
        q   <= sample;
        cnt <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/jamma_input_scanner.sv
// JAMMA player-input scanner: multiplexes the shared JJOY bus into two players.
// Debouncing is built only when JAMMA_DEBOUNCE_EN is defined; otherwise raw samples load directly.
//
// state     | meaning
// SETTLE_P1 | jselect=0, waiting SETTLE_CYCLES for the adapter to switch
// SAMPLE_P1 | capture player 1 (merged with the local DB9 joystick)
// SETTLE_P2 | jselect=1, waiting SETTLE_CYCLES
// SAMPLE_P2 | capture player 2, coin, test, service; scan_done high
module jamma_input_scanner
  import jamma_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [JOY_W-1:0]   jamma_joy,
  input  logic [COIN_W-1:0]  jamma_coin,
  input  logic               jamma_test,
  input  logic               jamma_service,
  input  logic [LOCAL_W-1:0] local_joy,
  output logic               jselect,
  output logic [JOY_W-1:0]   joy1,
  output logic [JOY_W-1:0]   joy2,
  output logic [COIN_W-1:0]  coin,
  output logic               test_n,
  output logic               service_n,
  output logic               scan_done
);

  localparam int SYNC_W = JOY_W + LOCAL_W + COIN_W + 2;
  localparam int OUT_W  = 2 * JOY_W + COIN_W + 2;

  logic [SYNC_W-1:0] sync_q1, sync_q2;
  logic [JOY_W-1:0]   joy_s, p1_raw;
  logic [LOCAL_W-1:0] local_s;
  logic [COIN_W-1:0]  coin_s;
  logic               test_s, service_s;
  logic [OUT_W-1:0]   sample_vec, sample_en, out_vec;

  scan_state_t state, state_nxt;
  logic [7:0]  settle_cnt;
  logic        settle_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= {jamma_service, jamma_test, jamma_coin, local_joy, jamma_joy};
      sync_q2 <= sync_q1;
    end
  end

  assign joy_s     = sync_q2[JOY_W-1:0];
  assign local_s   = sync_q2[JOY_W +: LOCAL_W];
  assign coin_s    = sync_q2[JOY_W+LOCAL_W +: COIN_W];
  assign test_s    = sync_q2[SYNC_W-2];
  assign service_s = sync_q2[SYNC_W-1];

  assign settle_done = (settle_cnt == 8'(SETTLE_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      SETTLE_P1: if (settle_done) state_nxt = SAMPLE_P1;
      SAMPLE_P1: state_nxt = SETTLE_P2;
      SETTLE_P2: if (settle_done) state_nxt = SAMPLE_P2;
      SAMPLE_P2: state_nxt = SETTLE_P1;
      default:   state_nxt = SETTLE_P1;
    endcase
  end

  // jselect tracks the state being entered so it is already stable while settling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SETTLE_P1;
      settle_cnt <= '0;
      jselect    <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= (state_nxt != state) ? 8'd0 : settle_cnt + 8'd1;
      jselect    <= (state_nxt == SETTLE_P2) || (state_nxt == SAMPLE_P2);
    end
  end

  assign scan_done = (state == SAMPLE_P2);

  // Player 1 buttons 7:6 have no DB9 equivalent, so only the direction/fire bits are merged
  assign p1_raw     = joy_s & {JOY_IDLE[JOY_W-1:LOCAL_W], local_s};
  assign sample_vec = {service_s, test_s, coin_s, joy_s, p1_raw};
  assign sample_en  = {{(OUT_W-JOY_W){state == SAMPLE_P2}}, {JOY_W{state == SAMPLE_P1}}};

`ifdef JAMMA_DEBOUNCE_EN
  for (genvar i = 0; i < OUT_W; i++) begin : g_deb
    jamma_debounce_bit #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .sample_en(sample_en[i]),
      .sample   (sample_vec[i]),
      .q        (out_vec[i])
    );
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vec <= '1;
    end else begin
      for (int i = 0; i < OUT_W; i++) begin
        if (sample_en[i]) out_vec[i] <= sample_vec[i];
      end
    end
  end
`endif

  assign joy1      = out_vec[JOY_W-1:0];
  assign joy2      = out_vec[2*JOY_W-1:JOY_W];
  assign coin      = out_vec[2*JOY_W +: COIN_W];
  assign test_n    = out_vec[OUT_W-2];
  assign service_n = out_vec[OUT_W-1];

endmodule
